// File: rtl/i2c_txn_arbiter_pkg.sv
// rtl/i2c_txn_arbiter_pkg.sv - shared types and constants for the I2C transaction arbiter
// Purpose: FSM state encoding, response error codes and I2C field widths.
// Ports: none (package).
package i2c_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// rtl/i2c_txn_arbiter_rr_pick.sv - combinational round-robin picker
// Purpose: find the first set request bit searching upward from ptr+1 (mod N).
// Ports: req (request vector), ptr (last winner index),
//        valid (any request set), onehot (winner), idx (winner index).
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    // k runs 1..N so the previous winner is considered last.
    for (int k = 1; k <= N; k++) begin
      if (!valid && req[(int'(ptr) + k) % N]) begin
        valid                     = 1'b1;
        onehot[(int'(ptr) + k) % N] = 1'b1;
        idx                       = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin arbiter sharing one I2C master among NUM_REQ clients
// Purpose: grant one requester, latch its command, strobe the master, wait for
//          completion or watchdog timeout, and return a one-cycle done pulse.
// Ports: clk/rst (async active-high); req/req_addr/req_rw/req_wdata client commands;
//        gnt/done/rsp_err/rsp_rdata client responses; m_start/m_addr/m_rw/m_wdata
//        master command; m_busy/m_done/m_ack_err/m_rdata master status.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TW          = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [1:0]                rsp_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      m_start,
  output logic [ADDR_W-1:0]         m_addr,
  output logic                      m_rw,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic                      m_busy,
  input  logic                      m_done,
  input  logic                      m_ack_err,
  input  logic [DATA_W-1:0]         m_rdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [TW-1:0]       cnt_q, cnt_d, cnt_nxt;
  logic [1:0]          err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                pick_valid;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IW-1:0]       pick_idx;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign cnt_nxt = cnt_q + TW'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_onehot;
          ptr_d   = pick_idx;
          addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          rw_d    = req_rw[pick_idx];
          wdata_d = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!m_busy) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_nxt;
        // m_done is tested first so it wins a tie with the watchdog.
        if (m_done) begin
          err_d   = {1'b0, m_ack_err};
          if (rw_q) rdata_d = m_rdata;
          done_d  = gnt_q;
          state_d = ST_RESP;
        end else if (cnt_nxt == TMO_LAST) begin
          err_d   = ERR_TMO;
          done_d  = gnt_q;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      err_q   <= ERR_OK;
      rdata_q <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
    end
  end

  // The strobe depends on the live m_busy so it fires in the same ISSUE cycle
  // the master becomes free.
  assign m_start   = (state_q == ST_ISSUE) && !m_busy;
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;
  assign m_addr    = addr_q;
  assign m_rw      = rw_q;
  assign m_wdata   = wdata_q;

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one I2C master between NUM_REQ independent requesters.
- Round-robin grants one requester at a time and latches its command (7-bit address, R/W, data byte).
- Sequences the master through start, completion and response, with a watchdog timeout.
- Sits between the system-side clients and the I2C_master datapath; the bit-level clock comes from the xung divider domain (same clk).

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 4096, clk cycles allowed between m_start and m_done before aborting.
- TW, 13, width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester level request.
- req_addr  in  7*NUM_REQ  slave address, slot i at [7i+6:7i].
- req_rw  in  NUM_REQ  1=read, 0=write.
- req_wdata  in  8*NUM_REQ  write byte, slot i at [8i+7:8i].
- gnt  out  NUM_REQ  one-hot grant, held ISSUE..RESP.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_err  out  2  00 ok, 01 NACK, 10 timeout; valid with done.
- rsp_rdata  out  8  read byte; valid with done when rw=1.
- m_start  out  1  one-cycle command strobe to the master.
- m_addr  out  7  latched address.
- m_rw  out  1  latched R/W.
- m_wdata  out  8  latched write byte.
- m_busy  in  1  master busy.
- m_done  in  1  master one-cycle completion.
- m_ack_err  in  1  slave NACK seen, valid with m_done.
- m_rdata  in  8  master read byte, valid with m_done.

Behaviour:
- Reset (async, immediate): state=IDLE; gnt, done, m_start=0; rsp_err=00; rsp_rdata, m_addr, m_rw, m_wdata=0; timeout counter=0; rr pointer=NUM_REQ-1, so req[0] has first priority.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, pick the first set bit searching from pointer+1 modulo NUM_REQ.
  - Latch that slot's addr/rw/wdata into m_*, set gnt one-hot, update pointer to the winner, go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE:
  - If m_busy=0, assert m_start for exactly this cycle, clear the counter, go to WAIT.
  - If m_busy=1, hold in ISSUE with no strobe and no timeout counting.
  - m_done in ISSUE is ignored.
- WAIT:
  - Counter increments each cycle.
  - m_done=1: latch rsp_err = {1'b0, m_ack_err} and rsp_rdata = m_rdata (rsp_rdata unchanged on write), go to RESP.
  - Counter reaches TIMEOUT_CYC-1 with m_done=0: rsp_err=10, rsp_rdata unchanged, go to RESP.
  - m_done and timeout expiry in the same cycle: m_done wins.
- RESP: done[winner]=1 for one cycle, gnt is cleared at the end of the cycle, return to IDLE.
- Latency: req sampled in IDLE at edge t -> gnt at t+1 -> m_start at t+1 (master idle) -> done one cycle after the m_done-sampling edge.
- Minimum request-to-done is 4 cycles plus the master transaction time.
- Requester rules:
  - A requester's req, addr, rw and wdata are sampled only in IDLE.
  - Dropping req after grant does not cancel the transaction.
  - A req still high in the IDLE cycle after done is a new request.
  - Request fields changing after grant have no effect.
- Fairness: no requester waits more than NUM_REQ-1 transactions while others are continuously requesting.
- Reset mid-transaction: the FSM aborts to IDLE with no done pulse. The master must share rst.

Decomposition:
- Package i2c_arb_pkg:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - error codes ERR_OK=2'b00, ERR_NACK=2'b01, ERR_TMO=2'b10;
  - I2C address width 7 and data width 8.
- Sub-module rr_pick: combinational, inputs req vector and pointer, outputs one-hot winner and its index. Reused by future multi-master blocks.

Test Plan:
- Single write: req=01, addr0=7'h50, rw0=0, wdata0=8'hAA; master pulses m_done with ack_err=0 twenty cycles after m_start -> one m_start, m_addr=50, m_wdata=AA, done=01, rsp_err=00, gnt cleared after RESP.
- Single read NACK: req=10, addr1=7'h3C, rw1=1; m_done with ack_err=1, m_rdata=8'h5A -> done=10, rsp_err=01, rsp_rdata=5A.
- Fairness: req=11 held for four transactions -> grant order 0,1,0,1; each done pulse is exactly one cycle.
- Busy stall and timeout: m_busy=1 for 10 cycles after grant -> no m_start and no counting; then m_done is never returned -> done with rsp_err=10 exactly TIMEOUT_CYC cycles after m_start.
- Tie: m_done asserted in the same cycle the counter hits TIMEOUT_CYC-1 -> rsp_err=00.
- Reset in WAIT -> immediate IDLE, gnt=0, no done; the next req=01 is granted normally.
